instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction fetch controller that sequences the combinational instruction memory. It owns the fetch PC, drives the memory address, and captures returned words into a 2-entry prefetch buffer. It presents them to decode with a valid/ready handshake. It handles branch redirects with a buffer flush, and stops fetching when it reads the all-zero word that marks the end of the program image.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset (must be 4-byte aligned)
- DEPTH, 2, prefetch buffer entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_en  in  1  fetch enable; low suspends new fetches, draining continues
- imem_addr  out  64  address to instruction memory; always equals fetch_pc register
- imem_data  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  branch/jump redirect request, single-cycle pulse
- redirect_pc  in  64  redirect target; bits [1:0] ignored (forced 0)
- out_valid  out  1  buffer head holds a valid instruction
- out_instr  out  32  instruction at buffer head
- out_pc  out  64  PC of out_instr
- out_ready  in  1  decode accepts head this cycle
- halted  out  1  end-of-program word fetched; fetching stopped

## Operation
- Reset values: fetch_pc=RESET_PC, state=IDLE, buffer count=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- States:
  - IDLE: no fetches. Goes to FETCH on an edge with fetch_en=1.
  - FETCH: fetches as described below.
  - HALT: no fetches, halted=1. Leaves only on redirect (to FETCH) or reset.
- pop = out_valid & out_ready. The head is removed at the edge.
- push = state==FETCH & fetch_en & !redirect_valid & (count<DEPTH | pop) & imem_data!=0.
  - On push, {imem_data, fetch_pc} enters the tail and fetch_pc += 4, wrapping modulo 2^64.
- End of program: state==FETCH & fetch_en & !redirect_valid & space available & imem_data==32'h0.
  - The word is not pushed and fetch_pc is unchanged.
  - State goes to HALT. Already-buffered entries still drain.
- Redirect, which has highest priority:
  - A pop in the same cycle completes; decode has taken the head.
  - All remaining entries are flushed: count=0, out_valid=0 after the edge.
  - fetch_pc={redirect_pc[63:2],2'b00}. State goes to FETCH from any state, including IDLE and HALT. halted clears.
  - No push occurs that cycle.
- fetch_en low in FETCH: no push, no halt detection, state held. Pops continue.
- Simultaneous push and pop when full: allowed. Count stays DEPTH and order is preserved.
- out_instr and out_pc hold their last values when out_valid=0. Only out_valid is meaningful.
- Unused buffer contents are not required to reset.

## Timing
- imem_addr is combinational from the fetch_pc register, so it changes only after clock edges or async reset.
- Fetch-to-valid latency: 1 cycle. A word pushed at edge N is at the head with out_valid=1 after edge N if the buffer was empty.
- Startup with fetch_en=1: edge 1 IDLE→FETCH, edge 2 pushes RESET_PC, out_valid=1 after edge 2.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Redirect: first target word is pushed at the edge after the redirect edge. out_valid=1 two edges after redirect_valid is sampled.
- Asynchronous reset mid-operation immediately forces all reset values, including imem_addr=RESET_PC. No handshake completes in a cycle where rst_n is low.

## Test plan
- Straight-line program: image D2E24689, D2CACF0B, D2B3578C, D29BDE0D repeated at 0x00–0x1C, 0 at 0x20; out_ready=1. Expect:
  - 8 transfers in order with out_pc 0x00..0x1C.
  - halted=1 after the fetch at 0x20.
  - imem_addr stays 0x20 and out_valid=0 after the drain.
- Backpressure: out_ready=0 for 5 cycles after startup. Expect:
  - count saturates at 2 with out_pc=0x00 held and imem_addr=0x08.
  - On release, 0x00, 0x04, 0x08 issue on consecutive cycles, with no loss or duplication.
- Redirect while full: with buffer holding 0x00/0x04, pulse redirect_valid, redirect_pc=0x13, out_ready=1. Expect:
  - the 0x00 transfer completes and 0x04 is flushed.
  - next out_pc=0x10 with out_instr=D2E24689, valid 2 edges later.
- Restart from HALT: after halt, redirect_pc=0x00. Expect halted=0 next cycle and the program re-fetched from 0x00.
- fetch_en toggling: deassert fetch_en for 3 cycles mid-run. Expect no pushes, fetch_pc frozen, and the buffer draining to empty; fetching resumes from the same PC.
- Async reset mid-run: drop rst_n between edges while out_valid=1. Expect out_valid=0, halted=0, and imem_addr=RESET_PC immediately, then normal startup after release.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory port, redirect input and decode-side handshake.
// Latency: none; this is wiring only.
// Backpressure: decode stalls the controller by holding out_ready low while out_valid is high.
interface instr_fetch_ctrl_if;
    logic        fetch_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        halted;

    // Controller side
    modport master (
        input  fetch_en,
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        output halted
    );

    // Environment side: memory, branch unit and decode
    modport slave (
        output fetch_en,
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer with a small prefetch FIFO, redirect flush and halt on the all-zero word.
// Latency: a word fetched at edge N is at the head after edge N when the buffer was empty.
// Backpressure: fetching stalls while the buffer is full and the head is not being popped.
module instr_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_ctrl_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q;
    logic            halted_q;
    logic [63:0]     fetch_pc_q;
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q;
    logic [31:0]     out_instr_q;
    logic [63:0]     out_pc_q;

    // Storage is deliberately left unreset; only count decides what is live.
    logic [31:0]     instr_mem [DEPTH];
    logic [63:0]     pc_mem    [DEPTH];

    logic            pop, space, fetch_ok, is_eop, push, eop;
    logic [CW-1:0]   remain;
    logic [PW-1:0]   head_nxt;

    // Handshake and fetch qualification for this cycle
    always_comb begin
        pop      = out_valid_q & bus.out_ready;
        space    = (count_q < CW'(DEPTH)) | pop;
        fetch_ok = (state_q == ST_FETCH) & bus.fetch_en & ~bus.redirect_valid & space;
        is_eop   = (bus.imem_data == 32'h0);
        push     = fetch_ok & ~is_eop;
        eop      = fetch_ok & is_eop;
        remain   = count_q - CW'(pop);
        head_nxt = head_q + PW'(pop);
        count_d  = remain + CW'(push);
    end

    // Control FSM; halted is a registered output of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.fetch_en) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (eop) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch buffer write port
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= bus.imem_data;
            pc_mem[tail_q]    <= fetch_pc_q;
        end
    end

    // Fetch PC, pointers and registered head; redirect flushes everything after any same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 64'h0;
        end else if (bus.redirect_valid) begin
            fetch_pc_q  <= {bus.redirect_pc[63:2], 2'b00};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                tail_q     <= tail_q + PW'(1);
                fetch_pc_q <= fetch_pc_q + 64'd4;
            end
            head_q      <= head_nxt;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            // Next head comes from storage if something survives the pop, else straight from memory
            if (remain != '0) begin
                out_instr_q <= instr_mem[head_nxt];
                out_pc_q    <= pc_mem[head_nxt];
            end else if (push) begin
                out_instr_q <= bus.imem_data;
                out_pc_q    <= fetch_pc_q;
            end
        end
    end

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Program image: four-word pattern at 0x00-0x1C, zero from 0x20, plus one word at the top of memory
    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        logic [31:0] w;
        w = 32'h0;
        if (a == 64'hFFFF_FFFF_FFFF_FFFC) w = 32'h1357_9BDF;
        else if (a < 64'h20) begin
            case (a[3:2])
                2'd0: w = 32'hD2E2_4689;
                2'd1: w = 32'hD2CA_CF0B;
                2'd2: w = 32'hD2B3_578C;
                default: w = 32'hD29B_DE0D;
            endcase
        end
        return w;
    endfunction

    always_comb bus.imem_data = mem_rd(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release on a falling edge; the next rising edge is startup edge 1
    task automatic do_reset(input logic fen, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.fetch_en       = fen;
        bus.out_ready      = rdy;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
        checks++; if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_regs: got pc=%h instr=%h want 0/0", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_straight();
        int n;
        int cyc;
        do_reset(1'b1, 1'b1);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL start_edge1_valid: got %b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin errors++; $display("FAIL start_edge2: got valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
        n = 0;
        cyc = 0;
        while (!(bus.halted === 1'b1 && bus.out_valid === 1'b0) && cyc < 40) begin
            if (bus.out_valid === 1'b1) begin
                checks++; if (bus.out_pc !== 64'(n * 4) || bus.out_instr !== mem_rd(64'(n * 4))) begin
                    errors++; $display("FAIL straight_xfer%0d: got pc=%h instr=%h want pc=%h instr=%h", n, bus.out_pc, bus.out_instr, 64'(n * 4), mem_rd(64'(n * 4)));
                end
                n++;
            end
            step();
            cyc++;
        end
        checks++; if (cyc >= 40) begin errors++; $display("FAIL straight_timeout: got %0d cycles want <40", cyc); end
        checks++; if (n != 8) begin errors++; $display("FAIL straight_count: got %0d transfers want 8", n); end
        step();
        step();
        checks++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL straight_halt: got halted=%b valid=%b want 1/0", bus.halted, bus.out_valid); end
        checks++; if (bus.imem_addr !== 64'h20) begin errors++; $display("FAIL straight_addr: got %h want 20", bus.imem_addr); end
    endtask

    // Starts from the halted state left by test_straight
    task automatic test_restart();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h0) begin
            errors++; $display("FAIL restart_edge: got halted=%b valid=%b addr=%h want 0/0/0", bus.halted, bus.out_valid, bus.imem_addr);
        end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'hD2E2_4689) begin
            errors++; $display("FAIL restart_first: got valid=%b pc=%h instr=%h want 1/0/d2e24689", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h4 || bus.out_instr !== 32'hD2CA_CF0B) begin
            errors++; $display("FAIL restart_second: got valid=%b pc=%h instr=%h want 1/4/d2cacf0b", bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_pc [3];
        exp_pc[0] = 64'h0; exp_pc[1] = 64'h4; exp_pc[2] = 64'h8;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.imem_addr !== 64'h8) begin
            errors++; $display("FAIL bp_full: got valid=%b pc=%h addr=%h want 1/0/8", bus.out_valid, bus.out_pc, bus.imem_addr);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_instr !== mem_rd(exp_pc[i])) begin
                errors++; $display("FAIL bp_release%0d: got valid=%b pc=%h instr=%h want 1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i], mem_rd(exp_pc[i]));
            end
            step();
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h13;
        bus.out_ready      = 1'b1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin errors++; $display("FAIL redir_head: got valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h10) begin
            errors++; $display("FAIL redir_flush: got valid=%b addr=%h want 0/10", bus.out_valid, bus.imem_addr);
        end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h10 || bus.out_instr !== 32'hD2E2_4689) begin
            errors++; $display("FAIL redir_target: got valid=%b pc=%h instr=%h want 1/10/d2e24689", bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_fetch_en();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8 || bus.imem_addr !== 64'hC) begin
            errors++; $display("FAIL fen_pre: got valid=%b pc=%h addr=%h want 1/8/c", bus.out_valid, bus.out_pc, bus.imem_addr);
        end
        bus.fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'hC) begin
                errors++; $display("FAIL fen_off%0d: got valid=%b addr=%h want 0/c", i, bus.out_valid, bus.imem_addr);
            end
        end
        bus.fetch_en = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hC || bus.out_instr !== 32'hD29B_DE0D) begin
            errors++; $display("FAIL fen_resume: got valid=%b pc=%h instr=%h want 1/c/d29bde0d", bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_wrap();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffffffffffc", bus.imem_addr); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.out_instr !== 32'h1357_9BDF || bus.imem_addr !== 64'h0) begin
            errors++; $display("FAIL wrap_push: got valid=%b pc=%h instr=%h addr=%h want 1/fffffffffffffffc/13579bdf/0", bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got valid=%b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== 64'h0) begin
            errors++; $display("FAIL arst_now: got valid=%b halted=%b addr=%h want 0/0/0", bus.out_valid, bus.halted, bus.imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_edge1: got valid=%b want 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin errors++; $display("FAIL arst_edge2: got valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        #12;
        test_reset();
        test_straight();
        test_restart();
        test_backpressure();
        test_redirect_full();
        test_fetch_en();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
